gray_counter_gen: RTL and testbench

//  Gray-code sequence generator that sits directly upstream of the Gray-to-binary decoder stage.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/binarytogray_d.sv | 12 +
 rtl/gray_counter_gen.sv | 97 +++++++++
 tb/tb_gray_counter_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequence generator.
// Provides the FSM state type, a binary-to-Gray function and terminal-value helpers.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } gc_state_t;

    // Widths up to 32 bits are covered; callers truncate to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Terminal count: all-ones when counting up, zero when counting down.
    function automatic logic [31:0] term_val(input logic up,
                                             input int unsigned w);
        logic [31:0] ones;
        ones = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return up ? ones : 32'd0;
    endfunction

endpackage

// File: rtl/binarytogray_d.sv
// Combinational binary-to-Gray converter.
// Ports: bin (binary in), gray (Gray-coded out), both WIDTH bits.
module binarytogray_d #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_gen.sv
// Gray-code sequence generator with valid/ready output, up/down, one-shot, load and tc.
// Ports: clk, rst, start, stop, up, oneshot, load, load_val, g_out, g_valid, g_ready, tc, busy.
module gray_counter_gen
    import gray_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] g_out,
    output logic             g_valid,
    input  logic             g_ready,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_RST  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] GRAY_RST = WIDTH'(bin2gray(32'(RST_VAL)));

    gc_state_t        state_q;
    gc_state_t        state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] gray_d;
    logic             xfer;
    logic             at_term;
    logic             tc_d;

    assign xfer    = g_valid & g_ready;
    assign at_term = (cnt_q == WIDTH'(term_val(up, WIDTH)));

    // Convert the next count so g_out is registered alongside cnt.
    binarytogray_d #(.WIDTH(WIDTH)) u_b2g (
        .bin  (cnt_d),
        .gray (gray_d)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;

        if (load) begin
            // Load wins: a word accepted this cycle is consumed without a step.
            cnt_d = load_val;
        end else begin
            if (xfer) begin
                tc_d = at_term;
                if (at_term && oneshot) begin
                    state_d = DONE;
                end else if (up) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            unique case (state_q)
                IDLE:    if (start) state_d = COUNT;
                COUNT:   if (stop)  state_d = IDLE;
                DONE:    if (start) state_d = COUNT;
                default: state_d = IDLE;
            endcase
        end

        // The unused encoding always recovers, even while load is held.
        if (state_q != IDLE && state_q != COUNT && state_q != DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_RST;
            g_out   <= GRAY_RST;
            g_valid <= 1'b0;
            busy    <= 1'b0;
            tc      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_out   <= gray_d;
            g_valid <= (state_d == COUNT);
            busy    <= (state_d == COUNT);
            tc      <= tc_d;
        end
    end

endmodule

// File: tb/tb_gray_counter_gen.sv
// Self-checking bench for gray_counter_gen with a behavioural reference model.
// Directed scenarios followed by randomized stimulus.
module tb_gray_counter_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       up;
    logic       oneshot;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] g_out;
    logic       g_valid;
    logic       g_ready;
    logic       tc;
    logic       busy;

    int checks;
    int errors;

    // Reference model: count as an integer, state as a small integer code.
    int         m_cnt;
    int         m_st;
    logic       m_tc;
    logic [3:0] exp_g;
    logic       exp_v;

    gray_counter_gen #(.WIDTH(4), .RST_VAL(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .up       (up),
        .oneshot  (oneshot),
        .load     (load),
        .load_val (load_val),
        .g_out    (g_out),
        .g_valid  (g_valid),
        .g_ready  (g_ready),
        .tc       (tc),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] decode(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic tick(input logic r, input logic s, input logic sp,
                        input logic u, input logic os, input logic ld,
                        input logic [3:0] lv, input logic rdy);
        int  nst;
        bit  acc;
        bit  term;
        rst = r; start = s; stop = sp; up = u; oneshot = os;
        load = ld; load_val = lv; g_ready = rdy;
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_st = 0; m_tc = 1'b0;
        end else begin
            acc  = (m_st == 1) && rdy;
            term = u ? (m_cnt == 15) : (m_cnt == 0);
            m_tc = 1'b0;
            nst  = m_st;
            if (ld) begin
                m_cnt = int'(lv);
            end else begin
                if (acc) begin
                    m_tc = term;
                    if (term && os) nst = 2;
                    else m_cnt = (m_cnt + (u ? 1 : 15)) % 16;
                end
                if (m_st == 1 && sp) nst = 0;
                else if (m_st != 1 && s) nst = 1;
                m_st = nst;
            end
        end
        exp_g = 4'(m_cnt ^ (m_cnt >> 1));
        exp_v = (m_st == 1);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 1, 0, 0, 4'h0, 0);
        checks++;
        if ({g_out, g_valid, tc, busy} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset: got g=%b v=%b tc=%b busy=%b want 0000 0 0 0",
                     g_out, g_valid, tc, busy);
        end
    endtask

    task automatic test_wrap_up();
        int tcs;
        tcs = 0;
        tick(1, 0, 0, 1, 0, 0, 4'h0, 1);
        tick(0, 1, 0, 1, 0, 0, 4'h0, 1);
        for (int i = 0; i < 17; i++) begin
            tick(0, 0, 0, 1, 0, 0, 4'h0, 1);
            checks++;
            if ({g_out, g_valid, busy, tc} !== {exp_g, exp_v, exp_v, m_tc}) begin
                errors++;
                $display("FAIL wrap_up[%0d]: got g=%b v=%b b=%b tc=%b want g=%b v=%b tc=%b",
                         i, g_out, g_valid, busy, tc, exp_g, exp_v, m_tc);
            end
            if (tc) begin
                tcs++;
                checks++;
                if (g_out !== 4'b0000) begin
                    errors++;
                    $display("FAIL wrap_tc_word: got g=%b want 0000", g_out);
                end
            end
        end
        checks++;
        if (tcs != 1) begin
            errors++;
            $display("FAIL wrap_tc_count: got %0d pulses want 1", tcs);
        end
    endtask

    task automatic test_oneshot_down();
        logic [3:0] seq [5];
        seq = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tick(1, 0, 0, 0, 1, 0, 4'h0, 1);
        tick(0, 0, 0, 0, 1, 1, 4'h3, 1);
        tick(0, 1, 0, 0, 1, 0, 4'h0, 1);
        checks++;
        if (g_out !== 4'b0010 || g_valid !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_first: got g=%b v=%b want 0010 1", g_out, g_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 1, 0, 4'h0, 1);
            checks++;
            if (g_out !== seq[i] || tc !== (i == 3) ||
                g_valid !== (i < 3) || busy !== (i < 3)) begin
                errors++;
                $display("FAIL oneshot[%0d]: got g=%b v=%b tc=%b want g=%b v=%b tc=%b",
                         i, g_out, g_valid, tc, seq[i], (i < 3), (i == 3));
            end
        end
    endtask

    task automatic test_ready_pattern();
        logic       pat [6];
        logic [3:0] prev;
        logic [3:0] want;
        bit         acc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tick(1, 0, 0, 1, 0, 0, 4'h0, 0);
        tick(0, 0, 0, 1, 0, 1, 4'h5, 0);
        tick(0, 1, 0, 1, 0, 0, 4'h0, 0);
        prev = decode(g_out);
        for (int i = 0; i < 6; i++) begin
            acc = g_valid && pat[i];
            tick(0, 0, 0, 1, 0, 0, 4'h0, pat[i]);
            want = acc ? prev + 4'd1 : prev;
            checks++;
            if (decode(g_out) !== want || g_out !== exp_g) begin
                errors++;
                $display("FAIL ready_pat[%0d]: got bin=%0d want %0d", i, decode(g_out), want);
            end
            prev = decode(g_out);
        end
    endtask

    task automatic test_load_xfer();
        tick(1, 0, 0, 1, 0, 0, 4'h0, 0);
        tick(0, 1, 0, 1, 0, 0, 4'h0, 0);
        tick(0, 0, 0, 1, 0, 1, 4'b1010, 1);
        checks++;
        if (g_out !== 4'b1111 || tc !== 1'b0 || g_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_xfer: got g=%b tc=%b v=%b want 1111 0 1", g_out, tc, g_valid);
        end
        tick(0, 0, 1, 1, 0, 0, 4'h0, 1);
        checks++;
        if (g_out !== 4'b1110 || g_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_xfer: got g=%b v=%b b=%b want 1110 0 0", g_out, g_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 1, 0, 0, 4'h0, 1);
        tick(0, 0, 0, 1, 0, 1, 4'hE, 1);
        tick(0, 1, 0, 1, 0, 0, 4'h0, 1);
        tick(0, 0, 0, 1, 0, 0, 4'h0, 1);
        tick(0, 0, 0, 1, 0, 0, 4'h0, 1);
        checks++;
        if (tc !== 1'b1 || g_out !== 4'b0000) begin
            errors++;
            $display("FAIL term_pulse: got tc=%b g=%b want 1 0000", tc, g_out);
        end
        tick(1, 0, 0, 1, 0, 0, 4'h0, 1);
        checks++;
        if ({g_out, g_valid, tc, busy} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_after_tc: got g=%b v=%b tc=%b b=%b want 0000 0 0 0",
                     g_out, g_valid, tc, busy);
        end
        tick(0, 1, 0, 0, 0, 0, 4'h0, 1);
        tick(0, 0, 0, 0, 0, 0, 4'h0, 1);
        tick(1, 0, 0, 0, 0, 0, 4'h0, 1);
        checks++;
        if ({g_out, g_valid, tc, busy} !== 7'b0000_000) begin
            errors++;
            $display("FAIL reset_mid: got g=%b v=%b tc=%b b=%b want 0000 0 0 0",
                     g_out, g_valid, tc, busy);
        end
    endtask

    task automatic test_random();
        logic r, s, sp, u, os, ld, rdy;
        logic [3:0] lv;
        tick(1, 0, 0, 1, 0, 0, 4'h0, 0);
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 59) == 0);
            s   = ($urandom_range(0, 4) == 0);
            sp  = ($urandom_range(0, 9) == 0);
            u   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            os  = $urandom_range(0, 1) == 1;
            ld  = ($urandom_range(0, 11) == 0);
            lv  = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 9) < 7);
            tick(r, s, sp, u, os, ld, lv, rdy);
            checks++;
            if ({g_out, g_valid, busy, tc} !== {exp_g, exp_v, exp_v, m_tc}) begin
                errors++;
                $display("FAIL random[%0d]: got g=%b v=%b b=%b tc=%b want g=%b v=%b tc=%b",
                         i, g_out, g_valid, busy, tc, exp_g, exp_v, m_tc);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_cnt = 0; m_st = 0; m_tc = 1'b0;
        exp_g = 4'h0; exp_v = 1'b0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; up = 1'b1; oneshot = 1'b0;
        load = 1'b0; load_val = 4'h0; g_ready = 1'b0;
        test_reset();
        test_wrap_up();
        test_oneshot_down();
        test_ready_pattern();
        test_load_xfer();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
